// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_irq,
   output logic [2:0] rx_count,
   output logic       overflow,
   output logic       frame_err,
   output logic       parity_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [BW-1:0] FULL_BIT = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic rx_m, rx_s, rx_s_d;
   logic [BW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   logic done, bad_stop, keep, push, pop, full, wr;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (!reset) {rx_m, rx_s, rx_s_d} <= 3'b111;
      else {rx_m, rx_s, rx_s_d} <= {UART_RX, rx_m, rx_s};
   end

   // Frame sequencing; stop-bit sample decides keep or frame error
   always_comb begin
      state_n = state;
      done = 1'b0;
      bad_stop = 1'b0;
      case (state)
         IDLE:  if (rx_s_d && !rx_s) state_n = START;
         START: if (cnt == HALF_BIT) state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:   if (cnt == FULL_BIT && idx == 3'd7) state_n = PARITY;
         PARITY: if (cnt == FULL_BIT) state_n = STOP;
`else
         DATA:  if (cnt == FULL_BIT && idx == 3'd7) state_n = STOP;
`endif
         STOP: if (cnt == FULL_BIT) begin
            state_n = IDLE;
            done = rx_s;
            bad_stop = !rx_s;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register, baud counter reloaded on every state entry, LSB-first shifter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt <= (state == IDLE || state_n != state || cnt == FULL_BIT) ? '0 : cnt + 1'b1;
         idx <= (state == START) ? 3'd0 : (state == DATA && cnt == FULL_BIT) ? idx + 1'b1 : idx;
         if (state == DATA && cnt == FULL_BIT) shift[idx] <= rx_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_hit;
   assign par_hit = state == PARITY && cnt == FULL_BIT && (rx_s ^ (^shift));
   assign keep = done && !par_bad;
   // Even-parity check: remember a failure for this frame and raise the sticky flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         par_bad <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad <= (state == START) ? 1'b0 : (par_bad || par_hit);
         parity_err <= (parity_err && !clr_err) || par_hit;
      end
   end
`else
   assign keep = done;
   assign parity_err = 1'b0;
`endif

   assign pop = rd_en && rx_valid;
   assign full = count == CW'(FIFO_DEPTH);
   assign wr = push && (!full || pop);
   assign rx_valid = count != '0;
   assign rx_irq = rx_valid;
   assign rx_data = mem[rd_ptr];
   assign rx_count = 3'(count);

   // FIFO: push lands the cycle after the stop sample; full push without pop drops the byte
   always_ff @(posedge clk) begin
      if (!reset) begin
         push <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         push <= keep;
         if (wr) begin
            mem[wr_ptr] <= shift;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr) - CW'(pop);
      end
   end

   // Sticky error flags; a new error wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow <= (overflow && !clr_err) || (push && full && !pop);
         frame_err <= (frame_err && !clr_err) || bad_stop;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clocks per bit, depth 4
module tb_uart_rx_fifo;
   localparam int N = 16;
   logic clk = 1'b0, reset = 1'b0, UART_RX = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] rx_data;
   logic [2:0] rx_count;
   logic rx_valid, rx_irq, overflow, frame_err, parity_err;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] exp_q[$];

   uart_rx_fifo #(.CLKS_PER_BIT(N), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .UART_RX(UART_RX), .rd_en(rd_en), .clr_err(clr_err),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_irq(rx_irq), .rx_count(rx_count),
      .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: every accepted pop is compared with the oldest expected byte
   always @(negedge clk) begin
      if (reset && rd_en && rx_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0h want nothing", rx_data);
         end else check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop();
      check("valid_before_pop", 32'(rx_valid), 32'd1);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   // mode 0: plain frame; 1: check push latency; 2: pop in the exact push cycle
   task automatic send_frame(input logic [7:0] d, input logic stop, input int mode);
      UART_RX = 1'b0;
      tick(N);
      for (int i = 0; i < 8; i++) begin
         UART_RX = d[i];
         tick(N);
      end
      UART_RX = stop;
      if (mode == 0) tick(N);
      else begin
         tick(11);
         if (mode == 1) check("valid_before_push", 32'(rx_valid), 32'd0);
         else rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
         if (mode == 1) check("valid_after_push", 32'(rx_valid), 32'd1);
         tick(4);
      end
      UART_RX = 1'b1;
      tick(4);
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, 32'(rx_valid), 32'd0);
      check({name, "_irq"}, 32'(rx_irq), 32'd0);
      check({name, "_count"}, 32'(rx_count), 32'd0);
      check({name, "_data"}, 32'(rx_data), 32'd0);
      check({name, "_ovf"}, 32'(overflow), 32'd0);
      check({name, "_ferr"}, 32'(frame_err), 32'd0);
      check({name, "_perr"}, 32'(parity_err), 32'd0);
   endtask

   // Directed stimulus
   initial begin
      tick(3);
      check_idle("reset");
      reset = 1'b1;
      tick(4);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1);
      check("a5_head", 32'(rx_data), 32'hA5);
      check("a5_count", 32'(rx_count), 32'd1);
      check("a5_irq", 32'(rx_irq), 32'd1);
      pop();
      check("a5_valid_after_pop", 32'(rx_valid), 32'd0);
      check("a5_count_after_pop", 32'(rx_count), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         if (i < 5) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1, 0);
      end
      check("ovf_count", 32'(rx_count), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      repeat (4) pop();
      check("ovf_drained", 32'(rx_count), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      foreach (exp_q[i]) check("queue_empty_mid", 32'(exp_q.size()), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(8'(i * 8'h11));
         send_frame(8'(i * 8'h11), 1'b1, 0);
      end
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 2);
      check("full_pp_count", 32'(rx_count), 32'd4);
      check("full_pp_ovf", 32'(overflow), 32'd0);
      repeat (4) pop();
      check("full_pp_drained", 32'(rx_count), 32'd0);
      UART_RX = 1'b0;
      tick(4);
      UART_RX = 1'b1;
      tick(40);
      check("glitch_count", 32'(rx_count), 32'd0);
      check("glitch_ferr", 32'(frame_err), 32'd0);
      check("glitch_ovf", 32'(overflow), 32'd0);
      send_frame(8'h3C, 1'b0, 0);
      check("ferr_flag", 32'(frame_err), 32'd1);
      check("ferr_count", 32'(rx_count), 32'd0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 0);
      check("ferr_good_head", 32'(rx_data), 32'h3C);
      check("ferr_still", 32'(frame_err), 32'd1);
      UART_RX = 1'b0;
      tick(N);
      for (int i = 0; i < 4; i++) begin
         UART_RX = 8'h7E >> i;
         tick(N);
      end
      UART_RX = 1'b1;
      tick(8);
      reset = 1'b0;
      exp_q.delete();
      tick(2);
      reset = 1'b1;
      tick(20);
      check_idle("midframe_reset");
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 0);
      check("7e_count", 32'(rx_count), 32'd1);
      pop();
      tick(2);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_count", 32'(rx_count), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front-end that sits upstream of the memory-mapped peripheral block.
- Deserialises the board UART_RX line (8N1, LSB first) into bytes and buffers them in a small first-word-fall-through FIFO.
- Exposes a pop handshake for the peripheral's read path.
- Drives a level interrupt that feeds the CPU IRQ path.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); legal range >= 4.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.

Ports:
- clk  input  1  system clock (25 MHz core clock).
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- UART_RX  input  1  asynchronous serial line; idle high.
- rd_en  input  1  pop request; 1-cycle pulse from peripheral read of RX data register.
- clr_err  input  1  clears sticky error flags.
- rx_data  output  8  FIFO head byte; valid when rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_irq  output  1  interrupt request; equals rx_valid.
- rx_count  output  3  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: byte dropped because FIFO was full.
- frame_err  output  1  sticky: stop bit sampled low.
- parity_err  output  1  sticky parity error; see Optional Feature.

Behaviour:
- Reset (reset=0 at posedge clk):
  - FSM to IDLE; FIFO pointers and count cleared.
  - Synchroniser flops set to 1.
  - rx_data=0, rx_valid=0, rx_irq=0, rx_count=0, overflow=0, frame_err=0, parity_err=0.
  - Reset asserted mid-frame aborts the frame; the partial byte is discarded.
- Input sync: UART_RX passes through 2 flops before use; all sampling uses the synchronised value (rx_s). A third flop holds rx_s_d for edge detection.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloaded at each state entry.
- FSM states:
  - IDLE: on falling edge (rx_s_d=1, rx_s=0) -> START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample rx_s. If 0 -> DATA with bit index 0. If 1 (glitch) -> IDLE, no flag.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[index], LSB first. After bit 7 -> STOP (or PARITY if the feature is enabled).
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: push the byte.
    - If 0: set frame_err, discard the byte.
    - Either way -> IDLE. A line held low (break) does not retrigger until a new falling edge.
- FIFO:
  - Push takes effect on the clock after the stop sample. rx_valid rises 1 cycle after the stop-bit mid-sample.
  - rx_data is combinational from the head entry; it is undefined-free (last value or 0) when empty.
  - Pop occurs on rd_en=1 when rx_valid=1. rd_en when empty is ignored; no underflow flag.
  - Simultaneous push and pop:
    - When full: both occur, count unchanged, no overflow.
    - When empty: count becomes 1 and the pushed byte is the head next cycle.
  - Push when full without pop: byte dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_err=1 clears overflow, frame_err and parity_err. If a new error occurs in the same cycle as clr_err, the flag ends at 1.
- rx_irq is a level signal; it stays 1 until the FIFO drains.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state follows DATA and samples one bit CLKS_PER_BIT later.
  - Received parity compared with XOR of the data bits (even parity).
  - On mismatch: parity_err set, byte discarded even if the stop bit is good.
  - A stop-bit error in the same frame also sets frame_err.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err tied to 0.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 (8N1) -> rx_valid=1 one cycle after the stop mid-sample; rx_data=0xA5, rx_count=1, rx_irq=1. Pulse rd_en -> rx_valid=0, rx_count=0.
- Send 0x01,0x02,0x03,0x04,0x05 without reading -> rx_count=4, overflow=1. Pops return 0x01..0x04. Pulse clr_err -> overflow=0.
- FIFO full; assert rd_en in the exact cycle 0x55 is pushed -> rx_count stays 4, overflow=0. Final pop yields 0x55.
- Low glitch of 4 cycles on UART_RX -> FSM returns to IDLE; rx_count=0, no flags.
- Send 0x3C with stop bit low -> frame_err=1, rx_count=0. Send 0x3C correctly -> rx_data=0x3C, frame_err still 1.
- Assert reset=0 at data bit 4 of a frame, then release -> all outputs 0. Next full frame 0x7E is received correctly.
